// File: rtl/huffman_decoder_pkg.sv
// Shared definitions for the canonical-Huffman decoder: sizes, FSM states,
// and the fixed code table (per-length counts and canonical symbol order).
package huffman_decoder_pkg;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 5;
    localparam int NSYM    = 8;
    localparam int LEN_W   = 3;
    // Wide enough to hold NSYM itself once every length has been passed.
    localparam int IDX_W   = 4;
    localparam int SYM_W   = 3;
    localparam int FIRST_W = MAX_LEN + 1;
    localparam int BCNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_EMIT,
        ST_ERR
    } state_t;

    // Number of codewords of each length: L1=0, L2..L5=2.
    function automatic logic [IDX_W-1:0] count_at(input logic [LEN_W-1:0] len);
        case (len)
            3'd2, 3'd3, 3'd4, 3'd5: count_at = 4'd2;
            default:                count_at = 4'd0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sym_at(input logic [SYM_W-1:0] idx);
        case (idx)
            3'd0:    sym_at = 8'h61; // a
            3'd1:    sym_at = 8'h64; // d
            3'd2:    sym_at = 8'h62; // b
            3'd3:    sym_at = 8'h63; // c
            3'd4:    sym_at = 8'h65; // e
            3'd5:    sym_at = 8'h66; // f
            3'd6:    sym_at = 8'h70; // p
            default: sym_at = 8'h6a; // j
        endcase
    endfunction

endpackage

// File: rtl/huffman_decoder_canon_step.sv
// One step of the canonical code walk: appends a bit and decides whether the
// extended code matches at its new length, or advances first/index.
module huffman_decoder_canon_step
    import huffman_decoder_pkg::*;
(
    input  logic [MAX_LEN-2:0] code_i,
    input  logic [FIRST_W-1:0] first_i,
    input  logic [IDX_W-1:0]   index_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               bit_i,
    output logic [MAX_LEN-2:0] code_o,
    output logic [LEN_W-1:0]   len_o,
    output logic               match_o,
    output logic [SYM_W-1:0]   sym_idx_o,
    output logic [FIRST_W-1:0] first_o,
    output logic [IDX_W-1:0]   index_o
);

    logic [MAX_LEN-1:0] code_full;
    logic [FIRST_W-1:0] code_ext;
    logic [FIRST_W-1:0] cnt_ext;
    logic [FIRST_W-1:0] offset;

    always_comb begin
        code_full = {code_i, bit_i};
        len_o     = len_i + 1'b1;
        cnt_ext   = FIRST_W'(count_at(len_o));
        code_ext  = FIRST_W'(code_full);
        offset    = code_ext - first_i;
        match_o   = (code_ext >= first_i) && (offset < cnt_ext);
        sym_idx_o = SYM_W'(index_i) + SYM_W'(offset);
        first_o   = (first_i + cnt_ext) << 1;
        index_o   = index_i + count_at(len_o);
        // A stored partial code never reaches MAX_LEN bits, so the top bit can drop.
        code_o    = code_full[MAX_LEN-2:0];
    end

endmodule

// File: rtl/huffman_decoder.sv
// Canonical-Huffman decoder: takes MSB-first code bytes, walks the code one bit
// per clock and emits 8-bit symbols; flags codewords unmatched at MAX_LEN.
module huffman_decoder
    import huffman_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [MAX_LEN-2:0]  code_q, code_d;
    logic [FIRST_W-1:0]  first_q, first_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;

    logic [MAX_LEN-2:0]  step_code;
    logic [LEN_W-1:0]    step_len;
    logic                step_match;
    logic [SYM_W-1:0]    step_sym;
    logic [FIRST_W-1:0]  step_first;
    logic [IDX_W-1:0]    step_index;

    huffman_decoder_canon_step u_step (
        .code_i    (code_q),
        .first_i   (first_q),
        .index_i   (index_q),
        .len_i     (len_q),
        .bit_i     (shreg_q[DATA_W-1]),
        .code_o    (step_code),
        .len_o     (step_len),
        .match_o   (step_match),
        .sym_idx_o (step_sym),
        .first_o   (step_first),
        .index_o   (step_index)
    );

    assign in_ready  = enable && (state_q == ST_LOAD) && (!out_valid_q || out_ready);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        code_d      = code_q;
        first_d     = first_q;
        index_d     = index_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        if (enable) begin
            // The symbol may retire in LOAD while the next byte is taken.
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: state_d = ST_LOAD;
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        shreg_d = in_data;
                        bcnt_d  = BCNT_W'(DATA_W);
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg_d = shreg_q << 1;
                    bcnt_d  = bcnt_q - 1'b1;
                    if (step_match) begin
                        out_data_d  = sym_at(step_sym);
                        out_valid_d = 1'b1;
                        code_d      = '0;
                        first_d     = '0;
                        index_d     = '0;
                        len_d       = '0;
                        state_d     = (bcnt_q == BCNT_W'(1)) ? ST_LOAD : ST_EMIT;
                    end else if (step_len == LEN_W'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        shreg_d = '0;
                        bcnt_d  = '0;
                        code_d  = '0;
                        first_d = '0;
                        index_d = '0;
                        len_d   = '0;
                        state_d = ST_ERR;
                    end else begin
                        // Partial code carries over into the next byte if this one runs out.
                        code_d  = step_code;
                        first_d = step_first;
                        index_d = step_index;
                        len_d   = step_len;
                        state_d = (bcnt_q == BCNT_W'(1)) ? ST_LOAD : ST_SHIFT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_ERR:  state_d = ST_LOAD;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bcnt_q      <= '0;
            code_q      <= '0;
            first_q     <= '0;
            index_q     <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcnt_q      <= bcnt_d;
            code_q      <= code_d;
            first_q     <= first_d;
            index_q     <= index_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule
